// File: rtl/uart_ram_loader.sv
// Boot loader: receives a framed image over UART and writes it into RAM via the override port.
// Latency: one byte per 10 bit times; each word is written one cycle after its 4th byte is received.
// Backpressure: ram_ack stalls WRITE, and a byte arriving during WRITE aborts the load to ERROR.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   rxd_async          raw serial input (idle high), synchronised internally
//   ram_override_ctrl  high while the loader owns the RAM port
//   ram_addr/ram_wdata word-aligned byte address and little-endian write data
//   ram_wen/ram_ack    write request held until acknowledged
//   cpu_hold           holds the core in reset during a load
//   load_done          1-cycle pulse when an image completes
//   load_err           sticky error, cleared by the next accepted sync byte or rst
module uart_ram_loader #(
  parameter int          CLKS_PER_BIT = 87,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd_async,
  output logic        ram_override_ctrl,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wen,
  input  logic        ram_ack,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

  // ---------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------
  logic            sync1_q, sync2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // ---------------------------------------------------------------
  // Loader state
  // ---------------------------------------------------------------
  ld_state_e       state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     word_q, word_d;
  logic            override_q, override_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            ram_wen_q, ram_wen_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;

  logic            rx_fall;
  logic            byte_last;
  logic [31:0]     len_next;
  logic            busy_d;

  // Falling edge seen on the synchronised line (previous high, now low).
  assign rx_fall = rx_prev_q & ~sync2_q;

  // ---------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the line mid start bit; a high level means it was a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!sync2_q) begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};  // LSB arrives first
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------
  assign byte_last = (byte_cnt_q == 2'd3);
  assign len_next  = {rx_shift_q, len_q[31:8]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_d     = word_q;
    load_err_d = load_err_q;

    case (state_q)
      ST_IDLE: begin
        // Framing errors while idle are line noise and are ignored.
        if (byte_valid_q && (rx_shift_q == SYNC_BYTE)) begin
          state_d    = ST_ADDR;
          load_err_d = 1'b0;
        end
      end
      ST_ADDR: begin
        if (frame_err_q) begin
          state_d = ST_ERROR;
        end else if (byte_valid_q) begin
          addr_d     = {rx_shift_q, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_last) begin
            addr_d[1:0] = 2'b00;
            state_d     = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (frame_err_q) begin
          state_d = ST_ERROR;
        end else if (byte_valid_q) begin
          len_d      = len_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_last) begin
            state_d = (len_next == 32'd0) ? ST_DONE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (frame_err_q) begin
          state_d = ST_ERROR;
        end else if (byte_valid_q) begin
          word_d     = {rx_shift_q, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_last) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // A new byte before the write completes means the RAM stalled too long.
        if (frame_err_q || byte_valid_q) begin
          state_d = ST_ERROR;
        end else if (ram_ack) begin
          addr_d  = addr_q + 32'd4;
          len_d   = len_q - 32'd1;
          state_d = (len_q == 32'd1) ? ST_DONE : ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = frame_err_q ? ST_ERROR : ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every field starts counting bytes from zero.
    if (state_d != state_q) begin
      byte_cnt_d = 2'd0;
    end
    if (state_d == ST_ERROR) begin
      load_err_d = 1'b1;
    end

    // Outputs are registered versions of the next-state decode.
    busy_d      = (state_d == ST_ADDR) || (state_d == ST_LEN) ||
                  (state_d == ST_DATA) || (state_d == ST_WRITE);
    override_d  = busy_d;
    cpu_hold_d  = busy_d;
    ram_wen_d   = (state_d == ST_WRITE);
    load_done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      addr_q       <= 32'd0;
      len_q        <= 32'd0;
      word_q       <= 32'd0;
      override_q   <= 1'b0;
      cpu_hold_q   <= 1'b0;
      ram_wen_q    <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sync1_q      <= rxd_async;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      word_q       <= word_d;
      override_q   <= override_d;
      cpu_hold_q   <= cpu_hold_d;
      ram_wen_q    <= ram_wen_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign ram_override_ctrl = override_q;
  assign ram_addr          = addr_q;
  assign ram_wdata         = word_q;
  assign ram_wen           = ram_wen_q;
  assign cpu_hold          = cpu_hold_q;
  assign load_done         = load_done_q;
  assign load_err          = load_err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: directed UART frames, scoreboard of expected writes and completions.
// Latency: frames are driven bit by bit at CLKS_PER_BIT=4.
// Backpressure: ram_ack is driven with a programmable delay.
module tb_uart_ram_loader;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd_async;
  logic        ram_ack;
  logic        ram_override_ctrl;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  uart_ram_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk               (clk),
    .rst               (rst),
    .rxd_async         (rxd_async),
    .ram_override_ctrl (ram_override_ctrl),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_wen           (ram_wen),
    .ram_ack           (ram_ack),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_err          (load_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cycles;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] done_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          ack_delay = 0;
  int          rx_bytes  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ram_ack responder: acknowledge after ack_delay cycles of ram_wen.
  initial begin
    int wen_cyc;
    wen_cyc = 0;
    ram_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ram_wen) begin
        ram_ack = (wen_cyc >= ack_delay);
        wen_cyc++;
      end else begin
        wen_cyc = 0;
        ram_ack = (ack_delay == 0);
      end
    end
  end

  // Monitor: pops expected writes and completions as the DUT presents them.
  initial begin
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        stable;
    logic        prev_done;
    int          cyc;
    wr_t         e;
    logic [31:0] ea;
    lat_addr = '0; lat_data = '0; stable = 1'b1; prev_done = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (dut.byte_valid_q) rx_bytes++;
      if (ram_wen) begin
        if (cyc == 0) begin
          lat_addr = ram_addr;
          lat_data = ram_wdata;
          stable   = 1'b1;
        end else if (ram_addr !== lat_addr || ram_wdata !== lat_data) begin
          stable = 1'b0;
        end
        cyc++;
        if (ram_ack) begin
          if (wr_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", ram_addr, ram_wdata);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", lat_addr, e.addr);
            check("wr_data", lat_data, e.data);
            check("wr_cycles", 32'(cyc), 32'(e.cycles));
            check("wr_stable", 32'(stable), 32'd1);
            check("wr_cpu_hold", 32'(cpu_hold), 32'd1);
          end
          cyc = 0;
        end
      end
      if (load_done) begin
        if (prev_done) begin
          total_cnt++;
          $display("FAIL done_width: got load_done high 2 cycles, required 1");
        end else if (done_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got load_done, none expected");
        end else begin
          ea = done_q.pop_front();
          check("done_addr", ram_addr, ea);
          check("done_cpu_hold", 32'(cpu_hold), 32'd0);
        end
      end
      prev_done = load_done;
    end
  end

  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    rxd_async = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rxd_async = b[i];
      wait_bit();
    end
    rxd_async = stop_bit;
    wait_bit();
    rxd_async = 1'b1;
    wait_bit();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    rxd_async = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({ram_override_ctrl, cpu_hold, ram_wen, load_done, load_err}), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Basic two-word load with ack tied high.
    ack_delay = 0;
    wr_q.push_back('{32'h0000_0100, 32'h0000_0013, 1});
    wr_q.push_back('{32'h0000_0104, 32'h0000_006F, 1});
    done_q.push_back(32'h0000_0108);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("basic_hold_after_sync", 32'(cpu_hold), 32'd1);
    check("basic_override_after_sync", 32'(ram_override_ctrl), 32'd1);
    send_word(32'h0000_0100);
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("basic_hold_released", 32'(cpu_hold), 32'd0);

    // Framing error in LEN.
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0400);
    send_byte(8'h02, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ferr_load_err", 32'(load_err), 32'd1);
    check("ferr_cpu_hold", 32'(cpu_hold), 32'd0);
    check("ferr_override", 32'(ram_override_ctrl), 32'd0);

    // Sync clears the error; then a zero-length image with misaligned address.
    done_q.push_back(32'h8000_0000);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("sync_clears_err", 32'(load_err), 32'd0);
    send_word(32'h8000_0003);
    send_word(32'h0000_0000);
    repeat (10) @(posedge clk);

    // Ack stalled by 3 cycles.
    ack_delay = 3;
    wr_q.push_back('{32'h0000_0010, 32'h1234_5678, 4});
    done_q.push_back(32'h0000_0014);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0010);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    repeat (10) @(posedge clk);
    ack_delay = 0;

    // Glitch then noise bytes in IDLE.
    base = rx_bytes;
    @(posedge clk);
    #1 rxd_async = 1'b0;
    @(posedge clk);
    #1 rxd_async = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_no_byte", 32'(rx_bytes - base), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("noise_bytes_seen", 32'(rx_bytes - base), 32'd2);
    check("noise_cpu_hold", 32'(cpu_hold), 32'd0);
    check("noise_override", 32'(ram_override_ctrl), 32'd0);

    // Reset after two data bytes aborts without a write.
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0300);
    send_word(32'h0000_0001);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", 32'({ram_override_ctrl, cpu_hold, ram_wen, load_done, load_err}), 32'd0);
    check("midrst_addr", ram_addr, 32'd0);
    repeat (5) @(posedge clk);

    // Full frame after the reset.
    wr_q.push_back('{32'h0000_0200, 32'hDEAD_BEEF, 1});
    done_q.push_back(32'h0000_0204);
    send_byte(8'hA5, 1'b1);
    send_word(32'h0000_0200);
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);

    for (int i = 0; i < 200 && (wr_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("dones_drained", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_ram_loader.md
# uart_ram_loader

Boot-time program loader between the board UART pin and the system's RAM debug/override port. It receives a framed image over a dedicated serial line. While loading, it holds the CPU in reset, takes over the RAM port, and writes the image word by word. On completion it releases both, and the core boots the freshly written program.

## Interface
Parameters:
- CLKS_PER_BIT, default 87: clk cycles per UART bit, at least 4. The default is 115200 baud at 10 MHz.
- SYNC_BYTE, default 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; the same clock that drives the system instance.
- rst  in  1  synchronous, active-high reset.
- rxd_async  in  1  raw serial input, asynchronous, idle high.
- ram_override_ctrl  out  1  high while the loader owns the RAM port.
- ram_addr  out  32  byte address, word-aligned.
- ram_wdata  out  32  write data, little-endian assembly.
- ram_wen  out  1  write request.
- ram_ack  in  1  write accepted in this cycle.
- cpu_hold  out  1  high holds the core in reset; the top uses nrst_sys = nrst & ~cpu_hold.
- load_done  out  1  pulses for 1 cycle when an image completes.
- load_err  out  1  sticky error flag; cleared on the next accepted SYNC_BYTE or on rst.

## Operation
Byte receiver (independent of the loader FSM):
- rxd_async passes through a 2-FF synchronizer, reset value 1.
- RX_IDLE → RX_START on a synced falling edge.
- RX_START waits CLKS_PER_BIT/2 cycles, then re-samples.
  - Low → RX_DATA.
  - High → glitch, return to RX_IDLE with no byte.
- RX_DATA samples 8 bits LSB first, every CLKS_PER_BIT cycles, then goes to RX_STOP.
- RX_STOP samples the stop bit.
  - 1 → 1-cycle byte_valid with byte.
  - 0 → 1-cycle frame_err.
  - Both cases return to RX_IDLE.

Loader FSM:
- IDLE: ignores every byte except SYNC_BYTE. On SYNC_BYTE: clear load_err, set cpu_hold, go to ADDR.
- ADDR: collects 4 bytes LE into base address and forces bits[1:0]=0. Then → LEN.
- LEN: collects 4 bytes LE into word count N (32-bit).
  - N=0 → DONE.
  - Otherwise → DATA.
- DATA: collects 4 bytes LE into a word, then → WRITE.
- WRITE:
  - Drives ram_wen=1 with ram_addr and ram_wdata held stable until the cycle ram_ack=1.
  - In that cycle: addr += 4 (wraps modulo 2^32), N -= 1.
  - Then → DONE if N reaches 0, else → DATA.
- DONE: 1 cycle. load_done=1, cpu_hold and ram_override_ctrl drop. Then → IDLE.
- ERROR: set load_err, drop cpu_hold and ram_override_ctrl, → IDLE on the next cycle.

ERROR entry conditions:
- frame_err in any state other than IDLE.
- byte_valid while in WRITE (overrun).
- frame_err in IDLE is ignored.

ram_override_ctrl is high in ADDR, LEN, DATA and WRITE. cpu_hold is high in the same states.

The byte count within a word or field is a 2-bit counter, reset on every state entry.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, receiver in RX_IDLE.
  - Synchronizer at 1.
  - Address, count and data registers 0.
- All outputs are registered.
- Byte latency: byte_valid occurs 2 synchronizer cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start edge at the pin (±1).
- The FSM consumes byte_valid in the same cycle it occurs. The WRITE entry is 1 cycle after the 4th data byte.
- ram_ack may be asserted in the first WRITE cycle, giving a 1-cycle write, or at any later cycle.
- ram_wen drops the cycle after ack.
- Any write stall longer than about one byte time causes overrun → ERROR.
- rst mid-frame aborts immediately with no write. cpu_hold is released, and load_err=0.
- Back-to-back images are legal. A SYNC_BYTE received the cycle after DONE starts a new load.

## Test plan
Directed tests use CLKS_PER_BIT=4 and SYNC_BYTE=A5.
- Basic load: send A5, addr 00 01 00 00, len 02 00 00 00, data 13 00 00 00 6F 00 00 00, with ram_ack tied to 1.
  - Writes 0x00000013 @0x00000100, then 0x0000006F @0x00000104.
  - One load_done pulse.
  - cpu_hold high from the cycle after A5 until DONE.
- Zero length: A5, addr 03 00 00 80, len 00 00 00 00.
  - No ram_wen.
  - load_done pulses.
  - Captured address 0x80000000: low bits were forced to 0.
- Ack stall: ram_ack delayed 3 cycles.
  - ram_wen, ram_addr and ram_wdata stay stable for 4 cycles.
  - Exactly one write occurs.
- Framing error: in LEN, send a byte with stop bit 0.
  - load_err=1, cpu_hold=0, no writes.
  - A subsequent A5 clears load_err.
- Glitch and noise:
  - A 1-cycle low pulse on rxd_async produces no byte.
  - Bytes 00 and FF received in IDLE leave the FSM in IDLE with cpu_hold=0.
- Reset mid-DATA: assert rst after 2 of the 4 data bytes.
  - All outputs 0 next cycle.
  - A new full frame then loads correctly.
